// File: rtl/rc5_pkg.sv
// rc5_pkg: shared types and default round keys for the 16-bit RC5 decoder.
package rc5_pkg;
  typedef logic [15:0] word_t;
  typedef logic [7:0]  half_t;
  localparam half_t S0_DEF = 8'h20;
  localparam half_t S1_DEF = 8'h10;
  localparam half_t S2_DEF = 8'hFF;
  localparam half_t S3_DEF = 8'hFF;
  typedef enum logic [2:0] {IDLE, DEC_B, DEC_A, UNWHITEN, HOLD} state_t;
endpackage

// File: rtl/rc5_rotr8.sv
// rc5_rotr8: combinational 8-bit rotate right.
//   d_i   - operand
//   amt_i - rotate amount (0 returns d_i unchanged)
//   r_o   - rotated result
module rc5_rotr8 (
  input  logic [7:0] d_i,
  input  logic [2:0] amt_i,
  output logic [7:0] r_o
);
  // Shifting the doubled operand lets the wrapped bits fall into the low byte.
  assign r_o = 8'({d_i, d_i} >> amt_i);
endmodule

// File: rtl/rc5_dec_16bit.sv
// rc5_dec_16bit: one-round 16-bit RC5 decoder with valid/ready handshakes.
//   clock, reset   - rising-edge clock, asynchronous active-low reset
//   ct_valid, ct   - ciphertext in ([15:8]=A, [7:0]=B), accepted when ct_ready
//   ct_ready       - high only in IDLE
//   pt_valid, pt   - plaintext out, held until pt_ready
//   busy           - high outside IDLE
//   blk_cnt        - delivered plaintext word count (wraps)
module rc5_dec_16bit
  import rc5_pkg::*;
#(
  parameter half_t S0 = S0_DEF,
  parameter half_t S1 = S1_DEF,
  parameter half_t S2 = S2_DEF,
  parameter half_t S3 = S3_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ct_valid,
  input  logic [15:0] ct,
  output logic        ct_ready,
  output logic        pt_valid,
  output logic [15:0] pt,
  input  logic        pt_ready,
  output logic        busy,
  output logic [7:0]  blk_cnt
);
  state_t state_q, state_d;
  word_t  ab_q, ab_d, pt_q, pt_d;
  logic   pt_valid_q, pt_valid_d;
  half_t  cnt_q, cnt_d;
  half_t  b_sub, a_sub, rot_b, rot_a;
  assign b_sub = ab_q[7:0] - S3;
  assign a_sub = ab_q[15:8] - S2;
  rc5_rotr8 u_rot_b (.d_i(b_sub), .amt_i(ab_q[10:8]), .r_o(rot_b));
  rc5_rotr8 u_rot_a (.d_i(a_sub), .amt_i(ab_q[2:0]),  .r_o(rot_a));
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ab_q       <= '0;
      pt_q       <= '0;
      pt_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ab_q       <= ab_d;
      pt_q       <= pt_d;
      pt_valid_q <= pt_valid_d;
      cnt_q      <= cnt_d;
    end
  end
  // DEC_A reads ab_q[7:0] after DEC_B has already rewritten it.
  always_comb begin
    state_d    = state_q;
    ab_d       = ab_q;
    pt_d       = pt_q;
    pt_valid_d = pt_valid_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: if (ct_valid) begin
        ab_d    = ct;
        state_d = DEC_B;
      end
      DEC_B: begin
        ab_d[7:0] = rot_b ^ ab_q[15:8];
        state_d   = DEC_A;
      end
      DEC_A: begin
        ab_d[15:8] = rot_a ^ ab_q[7:0];
        state_d    = UNWHITEN;
      end
      UNWHITEN: begin
        pt_d       = {ab_q[15:8] - S0, ab_q[7:0] - S1};
        pt_valid_d = 1'b1;
        state_d    = HOLD;
      end
      HOLD: if (pt_ready) begin
        pt_valid_d = 1'b0;
        cnt_d      = cnt_q + 8'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ct_ready = state_q == IDLE;
  assign busy     = state_q != IDLE;
  assign pt       = pt_q;
  assign pt_valid = pt_valid_q;
  assign blk_cnt  = cnt_q;
endmodule

// File: tb/tb_rc5_dec_16bit.sv
// tb_rc5_dec_16bit: table-driven and scoreboarded checks of rc5_dec_16bit.
module tb_rc5_dec_16bit;
  logic        clock = 1'b0, reset = 1'b0, ct_valid = 1'b0, pt_ready = 1'b0;
  logic [15:0] ct = '0;
  logic        ct_ready, pt_valid, busy;
  logic [15:0] pt;
  logic [7:0]  blk_cnt;
  rc5_dec_16bit dut (
    .clock(clock), .reset(reset), .ct_valid(ct_valid), .ct(ct), .ct_ready(ct_ready),
    .pt_valid(pt_valid), .pt(pt), .pt_ready(pt_ready), .busy(busy), .blk_cnt(blk_cnt)
  );
  always #5 clock = ~clock;
  typedef struct {logic [15:0] ct; logic [15:0] pt;} vec_t;
  vec_t        tbl[8];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] exp_q[$];
  int          lat_q[$];
  logic [15:0] cur_exp = '0;
  logic        pv_prev = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction
  // Forward RC5 with the default keys; the decoder must invert it.
  function automatic logic [15:0] enc(input logic [15:0] p);
    logic [7:0] a, b;
    a = p[15:8] + 8'h20;
    b = p[7:0] + 8'h10;
    a = rotl8(a ^ b, int'(b[2:0])) + 8'hFF;
    b = rotl8(b ^ a, int'(a[2:0])) + 8'hFF;
    return {a, b};
  endfunction
  always @(posedge clock) cyc <= cyc + 1;
  // Monitor samples mid-cycle: outputs settled, inputs for the next edge already driven.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      lat_q.delete();
      pv_prev = 1'b0;
    end else begin
      chk("ready_vs_busy", {31'd0, ct_ready}, {31'd0, ~busy});
      if (pt_valid && !pv_prev) begin
        if (lat_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_pt_valid: got pt_valid=1 with no word in flight, expected 0");
        end else chk("latency", cyc - lat_q.pop_front(), 3);
      end
      if (pt_valid && pt_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pt: got pt=%h with empty scoreboard, expected none", pt);
        end else chk("pt", pt, exp_q.pop_front());
      end
      if (ct_ready && ct_valid) begin
        exp_q.push_back(cur_exp);
        lat_q.push_back(cyc + 1);
      end
      pv_prev = pt_valid;
    end
  end
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic chk_reset_vals();
    chk("rst_pt", pt, 16'h0000);
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ct_ready", ct_ready, 1);
  endtask
  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!ct_ready && k < 40) begin
      tick();
      k++;
    end
    chk({name, "_timeout"}, ct_ready, 1);
  endtask
  task automatic send(input logic [15:0] c, input logic [15:0] e);
    wait_idle("send");
    ct = c;
    cur_exp = e;
    ct_valid = 1'b1;
    tick();
    ct_valid = 1'b0;
  endtask
  initial begin
    logic [7:0]  c0;
    logic [15:0] p;
    int          last, acc, k;
    reset = 1'b0;
    #1 chk_reset_vals();
    tick();
    reset = 1'b1;
    tick();
    chk("ready_after_reset", ct_ready, 1);
    pt_ready = 1'b1;
    send(16'h2F9E, 16'h0000);
    wait_idle("first");
    chk("first_blk_cnt", blk_cnt, 1);
    tbl[0] = '{16'h2F9E, 16'h0000};
    tbl[1] = '{16'h6687, 16'h1234};
    tbl[2] = '{enc(16'hFFFF), 16'hFFFF};
    tbl[3] = '{enc(16'h8000), 16'h8000};
    tbl[4] = '{enc(16'h0001), 16'h0001};
    for (int i = 5; i < 8; i++) begin
      p = 16'($urandom);
      tbl[i] = '{enc(p), p};
    end
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].ct, tbl[i].pt);
      wait_idle("table");
    end
    chk("table_blk_cnt", blk_cnt, 9);
    ct = 16'h2F9E;
    cur_exp = 16'h0000;
    ct_valid = 1'b1;
    last = -1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (ct_ready) begin
        if (last >= 0) chk("accept_gap", i - last, 5);
        last = i;
        acc++;
      end
      tick();
    end
    ct_valid = 1'b0;
    chk("accept_count", acc, 8);
    wait_idle("stream");
    pt_ready = 1'b0;
    send(16'h6687, 16'h1234);
    k = 0;
    while (!pt_valid && k < 10) begin
      tick();
      k++;
    end
    chk("hold_reached", pt_valid, 1);
    for (int i = 0; i < 10; i++) begin
      ct = 16'hAAAA;
      ct_valid = i[0];
      tick();
      chk("hold_pt", pt, 16'h1234);
      chk("hold_pt_valid", pt_valid, 1);
      chk("hold_ct_ready", ct_ready, 0);
    end
    ct_valid = 1'b0;
    c0 = blk_cnt;
    pt_ready = 1'b1;
    tick();
    chk("release_cnt", blk_cnt, 32'(8'(c0 + 8'd1)));
    chk("release_pt_valid", pt_valid, 0);
    chk("release_pt_kept", pt, 16'h1234);
    chk("release_ct_ready", ct_ready, 1);
    send(16'h6687, 16'h1234);
    tick();
    reset = 1'b0;
    #1 chk_reset_vals();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("no_pulse_after_reset", pt_valid, 0);
    send(16'h6687, 16'h1234);
    wait_idle("post_reset");
    chk("post_reset_cnt", blk_cnt, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      p = 16'($urandom);
      send(enc(p), p);
      wait_idle("wrap");
      if (i == 254) chk("cnt_ff", blk_cnt, 8'hFF);
    end
    chk("cnt_wrap", blk_cnt, 8'h00);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rc5_dec_16bit.md
RC5_DEC_16BIT -- requirements
Module: rc5_dec_16bit

Interface
REQ-001 The block SHALL have parameter S0, default 8'h20, round key word 0 (A whitening).
REQ-002 The block SHALL have parameter S1, default 8'h10, round key word 1 (B whitening).
REQ-003 The block SHALL have parameter S2, default 8'hFF, round key word 2 (A round).
REQ-004 The block SHALL have parameter S3, default 8'hFF, round key word 3 (B round).
REQ-005 Port clock, input, 1 bit: clock; all state changes on the rising edge.
REQ-006 Port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port ct_valid, input, 1 bit: ciphertext word is present on ct.
REQ-008 Port ct, input, 16 bits: ciphertext; [15:8] = A, [7:0] = B.
REQ-009 Port ct_ready, output, 1 bit: block can accept a ciphertext this cycle.
REQ-010 Port pt_valid, output, 1 bit: recovered plaintext is present on pt.
REQ-011 Port pt, output, 16 bits: recovered plaintext; [15:8] = A, [7:0] = B.
REQ-012 Port pt_ready, input, 1 bit: consumer accepts pt this cycle.
REQ-013 Port busy, output, 1 bit: high in every state except IDLE.
REQ-014 Port blk_cnt, output, 8 bits: count of plaintext words delivered.

Function
REQ-015 FSM states SHALL be IDLE, DEC_B, DEC_A, UNWHITEN and HOLD.
REQ-016 ct_ready SHALL equal (state == IDLE), combinational from the state register only.
REQ-017 IDLE with ct_valid=1 at a rising edge: the block SHALL capture ct into an internal A/B register and move to DEC_B; with ct_valid=0 it SHALL stay in IDLE.
REQ-018 DEC_B: B <= rotr8((B - S3) mod 256, A mod 8) ^ A; next state DEC_A.
REQ-019 DEC_A: A <= rotr8((A - S2) mod 256, B mod 8) ^ B, using the B value written in DEC_B; next state UNWHITEN.
REQ-020 UNWHITEN: pt <= {(A - S0) mod 256, (B - S1) mod 256}; pt_valid <= 1; next state HOLD.
REQ-021 All arithmetic SHALL be 8-bit modulo 256; a rotate amount of 0 SHALL return the operand unchanged.
REQ-022 Latency: pt_valid SHALL rise exactly 3 rising edges after the ct acceptance edge.
REQ-023 HOLD: pt and pt_valid SHALL stay stable until pt_ready=1 at a rising edge.
REQ-024 On that edge the block SHALL clear pt_valid, increment blk_cnt and return to IDLE; pt keeps its last value.
REQ-025 blk_cnt SHALL wrap from 8'hFF to 8'h00 without any other side effect.
REQ-026 ct_valid in any state other than IDLE SHALL be ignored; ct is not sampled and no error is raised.
REQ-027 pt_ready while pt_valid=0 SHALL be ignored.
REQ-028 pt_ready=1 already asserted when HOLD is entered SHALL complete the handshake on the first HOLD edge.
REQ-029 Output-side and input-side handshakes SHALL never complete in the same cycle, so the maximum throughput is one word per 5 cycles.

Reset
REQ-030 reset low SHALL asynchronously force: state=IDLE, pt=16'h0000, pt_valid=0, blk_cnt=8'h00, and the internal A/B register=16'h0000.
REQ-031 reset asserted mid-operation SHALL discard the in-flight word with no partial pt_valid pulse.
REQ-032 After reset deasserts, ct_ready SHALL be 1 in the first cycle.

Structure
REQ-033 Package rc5_pkg SHALL hold the default S-box constants (8'h20, 8'h10, 8'hFF, 8'hFF), the 16-bit word and 8-bit half-word typedefs, and the decoder state enum.
REQ-034 The 8-bit rotate-right SHALL be a sub-module rc5_rotr8: combinational, 8-bit data in, 3-bit amount in, 8-bit result out; it is instantiated twice.

Verification
REQ-035 Reset, then ct=16'h2F9E with ct_valid=1 for one cycle and pt_ready=1 -> pt=16'h0000 with pt_valid high 3 edges after acceptance; blk_cnt=1.
REQ-036 ct=16'h6687 -> pt=16'h1234.
REQ-037 pt_ready held at 0 for 10 cycles in HOLD -> pt and pt_valid stable, ct_ready=0, ct_valid pulses ignored; on release, blk_cnt increments by exactly 1.
REQ-038 ct_valid held high continuously with pt_ready=1 and ct=16'h2F9E -> one acceptance every 5 cycles; ct_ready never high while busy=1.
REQ-039 reset pulsed low during DEC_A -> all outputs at their reset values immediately, no pt_valid pulse, normal decode of the next word.
REQ-040 256 back-to-back decodes -> blk_cnt returns to 8'h00.
